// File: rtl/fec_pkg.sv
// Shared constants, scrambler definition and uplink transmitter state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fec_pkg;

    localparam int DL_PREAMBLE_COUNT = 8;
    localparam int UL_ID_WIDTH       = 4;
    localparam int UL_DATA_WIDTH     = 16;

    // Scrambler polynomial x^7 + x^4 + 1: feedback from bits 6 and 3.
    localparam logic [6:0] UL_SCRAMBLE_SEED = 7'h7F;
    localparam logic [6:0] UL_SCRAMBLE_TAPS = 7'b100_1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_MESSAGE_ID,
        S_MESSAGE_DATA,
        S_DONE
    } ul_tx_state_t;

    // One scrambler step: shift left, feedback enters at bit 0.
    function automatic logic [6:0] ul_scramble_step(input logic [6:0] s);
        return {s[5:0], ^(s & UL_SCRAMBLE_TAPS)};
    endfunction

endpackage

// File: rtl/ul_scrambler.sv
// 7-bit additive scrambler LFSR; bit_out is the current keystream bit.
// Latency: seed_load/advance take effect on the next clk edge.
// Backpressure: none; the owner decides when to advance.
module ul_scrambler
    import fec_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic seed_load,
    input  logic advance,
    output logic bit_out
);

    logic [6:0] lfsr_q;

    // Seed load wins over advance so a new frame always starts from the seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= UL_SCRAMBLE_SEED;
        end else if (seed_load) begin
            lfsr_q <= UL_SCRAMBLE_SEED;
        end else if (advance) begin
            lfsr_q <= ul_scramble_step(lfsr_q);
        end
    end

    assign bit_out = lfsr_q[6];

endmodule

// File: rtl/uplink_transmitter.sv
// Serialises one frame (alternating preamble, scrambled ID, scrambled data, MSB first).
// Latency: first bit the cycle after acceptance; done after (P+ID+DATA)*(clk_div+1)+1 cycles.
// Backpressure: ready only in idle; start while busy is dropped, not queued.
module uplink_transmitter
    import fec_pkg::*;
#(
    parameter int SERIAL_DIV_WIDTH = 8,
    parameter int PREAMBLE_COUNT   = DL_PREAMBLE_COUNT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SERIAL_DIV_WIDTH-1:0] clk_div,
    input  logic                        start,
    input  logic [UL_ID_WIDTH-1:0]      msg_id,
    input  logic [UL_DATA_WIDTH-1:0]    msg_data,
    output logic                        ready,
    output logic                        done,
    output logic                        ul_out,
    output logic                        ul_en
);

    localparam int MAX_BITS = (PREAMBLE_COUNT > UL_DATA_WIDTH) ? PREAMBLE_COUNT : UL_DATA_WIDTH;
    localparam int IDX_W    = (MAX_BITS > 2) ? $clog2(MAX_BITS) : 1;

    localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PREAMBLE_COUNT - 1);
    localparam logic [IDX_W-1:0] ID_LAST   = IDX_W'(UL_ID_WIDTH - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(UL_DATA_WIDTH - 1);

    ul_tx_state_t                state_q, state_d;
    logic [SERIAL_DIV_WIDTH-1:0] div_q;
    logic [SERIAL_DIV_WIDTH-1:0] bit_cnt_q;
    logic [IDX_W-1:0]            bit_idx_q;
    logic [UL_ID_WIDTH-1:0]      id_sh_q;
    logic [UL_DATA_WIDTH-1:0]    data_sh_q;

    logic accept;
    logic bit_end;
    logic scr_advance;
    logic scr_bit;

    assign accept  = start && (state_q == S_IDLE);
    assign bit_end = (bit_cnt_q == div_q);

    ul_scrambler u_scrambler (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (accept),
        .advance   (scr_advance),
        .bit_out   (scr_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and line outputs; outputs decode directly from state so reset clears them at once.
    always_comb begin
        state_d     = state_q;
        ready       = 1'b0;
        done        = 1'b0;
        ul_en       = 1'b0;
        ul_out      = 1'b0;
        scr_advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_d = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                ul_en  = 1'b1;
                ul_out = ~bit_idx_q[0];
                if (bit_end && (bit_idx_q == PRE_LAST)) begin
                    state_d = S_MESSAGE_ID;
                end
            end
            S_MESSAGE_ID: begin
                ul_en       = 1'b1;
                ul_out      = id_sh_q[UL_ID_WIDTH-1] ^ scr_bit;
                scr_advance = bit_end;
                if (bit_end && (bit_idx_q == ID_LAST)) begin
                    state_d = S_MESSAGE_DATA;
                end
            end
            S_MESSAGE_DATA: begin
                ul_en       = 1'b1;
                ul_out      = data_sh_q[UL_DATA_WIDTH-1] ^ scr_bit;
                scr_advance = bit_end;
                if (bit_end && (bit_idx_q == DATA_LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Cycle-in-bit and bit-in-state counters; both restart on any state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
        end else if (state_d != state_q) begin
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
        end else if (ul_en && bit_end) begin
            bit_cnt_q <= '0;
            bit_idx_q <= bit_idx_q + IDX_W'(1);
        end else if (ul_en) begin
            bit_cnt_q <= bit_cnt_q + SERIAL_DIV_WIDTH'(1);
        end
    end

    // Frame parameters captured at acceptance; ID and data shift out MSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            id_sh_q   <= '0;
            data_sh_q <= '0;
        end else if (accept) begin
            div_q     <= clk_div;
            id_sh_q   <= msg_id;
            data_sh_q <= msg_data;
        end else if (bit_end && (state_q == S_MESSAGE_ID)) begin
            id_sh_q   <= {id_sh_q[UL_ID_WIDTH-2:0], 1'b0};
        end else if (bit_end && (state_q == S_MESSAGE_DATA)) begin
            data_sh_q <= {data_sh_q[UL_DATA_WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_uplink_transmitter.sv
// Scoreboard bench: stimulus pushes expected frames, monitor decodes the serial line and compares.
module tb_uplink_transmitter;
    import fec_pkg::*;

    localparam int NBITS = 8 + 4 + 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  clk_div = '0;
    logic        start = 1'b0;
    logic [3:0]  msg_id = '0;
    logic [15:0] msg_data = '0;
    logic        ready, done, ul_out, ul_en;

    uplink_transmitter #(.SERIAL_DIV_WIDTH(8), .PREAMBLE_COUNT(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_div  (clk_div),
        .start    (start),
        .msg_id   (msg_id),
        .msg_data (msg_data),
        .ready    (ready),
        .done     (done),
        .ul_out   (ul_out),
        .ul_en    (ul_en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  id;
        logic [15:0] data;
        int          div;
        int          acc;
        bit          chk_raw;
        logic [7:0]  raw_hi;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   in_frame = 1'b0;
    logic samples[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decode a completed frame from the collected line samples.
    task automatic finish_frame();
        int          bp;
        logic [27:0] bits;
        logic        hold_ok;
        logic [7:0]  pre;
        logic [6:0]  lf;
        logic [3:0]  id_rx;
        logic [15:0] data_rx;
        logic [19:0] raw;
        bp = cur.div + 1;
        check("done_pulse", done, 1);
        check("frame_len", samples.size(), NBITS * bp);
        check("done_latency", cyc, cur.acc + NBITS * bp + 1);
        if (samples.size() == NBITS * bp) begin
            hold_ok = 1'b1;
            for (int i = 0; i < NBITS; i++) begin
                bits[i] = samples[i * bp];
                for (int j = 1; j < bp; j++)
                    if (samples[i * bp + j] !== samples[i * bp]) hold_ok = 1'b0;
            end
            check("bit_hold", hold_ok, 1);
            for (int i = 0; i < 8; i++) pre[7 - i] = bits[i];
            check("preamble", pre, 8'hAA);
            lf = 7'h7F;
            id_rx = '0;
            data_rx = '0;
            for (int i = 0; i < 20; i++) begin
                raw[19 - i] = bits[8 + i];
                if (i < 4) id_rx = {id_rx[2:0], bits[8 + i] ^ lf[6]};
                else       data_rx = {data_rx[14:0], bits[8 + i] ^ lf[6]};
                lf = {lf[5:0], lf[6] ^ lf[3]};
            end
            check("msg_id", id_rx, cur.id);
            check("msg_data", data_rx, cur.data);
            if (cur.chk_raw) check("raw_scrambled", raw[19:12], cur.raw_hi);
        end
        samples.delete();
    endtask

    // Monitor: follows the line every cycle, independent of the stimulus.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (in_frame) begin
                    in_frame = 1'b0;
                    samples.delete();
                end
                check("rst_ul_en", ul_en, 0);
                check("rst_ul_out", ul_out, 0);
                check("rst_done", done, 0);
            end else if (ul_en) begin
                if (!in_frame) begin
                    if (sb.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                        cur = '{id: 4'h0, data: 16'h0, div: 0, acc: cyc - 1, chk_raw: 1'b0, raw_hi: 8'h0};
                    end else begin
                        cur = sb.pop_front();
                        check("first_bit_cycle", cyc, cur.acc + 1);
                    end
                    in_frame = 1'b1;
                end
                check("done_in_frame", done, 0);
                samples.push_back(ul_out);
            end else if (in_frame) begin
                in_frame = 1'b0;
                finish_frame();
            end else begin
                check("idle_done", done, 0);
                check("idle_ul_out", ul_out, 0);
            end
        end
    end

    // Present a frame, wait for acceptance, then scramble the inputs to prove they were latched.
    task automatic issue(input logic [3:0] id, input logic [15:0] data, input int div,
                         input bit chk_raw, input logic [7:0] raw_hi, output int acc);
        @(posedge clk);
        #1;
        msg_id   = id;
        msg_data = data;
        clk_div  = 8'(div);
        start    = 1'b1;
        acc      = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (ready) begin
                acc = cyc;
                sb.push_back('{id: id, data: data, div: div, acc: cyc, chk_raw: chk_raw, raw_hi: raw_hi});
                break;
            end
        end
        if (acc < 0) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        start    = 1'b0;
        msg_id   = ~id;
        msg_data = ~data;
        clk_div  = 8'(div + 2);
    endtask

    task automatic wait_ready();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("ready_timeout", 0, 1);
    endtask

    int acc0, acc1, acc2;
    int held_acc[3];
    logic [3:0]  held_id[3]   = '{4'h1, 4'h2, 4'h3};
    logic [15:0] held_data[3] = '{16'h1111, 16'hA5A5, 16'hFFFF};

    initial begin
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", ready, 1);
        check("reset_ul_en", ul_en, 0);
        check("reset_done", done, 0);

        // ID A, data 0, 1-cycle bits: scrambled ID 0101, first data nibble 1110.
        issue(4'hA, 16'h0000, 0, 1'b1, 8'h5E, acc0);
        wait_ready();

        // 4-cycle bits: 112 enabled cycles, done at +113.
        issue(4'h5, 16'h1234, 3, 1'b0, 8'h00, acc0);
        wait_ready();

        // Start pulse mid-frame with another ID must be dropped.
        issue(4'h3, 16'hC0DE, 1, 1'b0, 8'h00, acc0);
        repeat (10) @(posedge clk);
        #1;
        start  = 1'b1;
        msg_id = 4'hC;
        @(negedge clk);
        check("ready_busy", ready, 0);
        @(posedge clk);
        #1 start = 1'b0;
        wait_ready();

        // Start held high across three frames.
        @(posedge clk);
        #1;
        clk_div  = 8'd0;
        msg_id   = held_id[0];
        msg_data = held_data[0];
        start    = 1'b1;
        for (int f = 0; f < 3; f++) begin
            held_acc[f] = -1;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (ready) begin
                    held_acc[f] = cyc;
                    sb.push_back('{id: held_id[f], data: held_data[f], div: 0, acc: cyc, chk_raw: 1'b0, raw_hi: 8'h00});
                    break;
                end
            end
            if (held_acc[f] < 0) check("held_accept_timeout", 0, 1);
            @(posedge clk);
            #1;
            if (f < 2) begin
                msg_id   = held_id[f + 1];
                msg_data = held_data[f + 1];
            end else begin
                start = 1'b0;
            end
        end
        check("held_period_1", held_acc[1] - held_acc[0], NBITS + 2);
        check("held_period_2", held_acc[2] - held_acc[1], NBITS + 2);
        wait_ready();

        // Reset during the data field, then a freshly seeded frame.
        issue(4'h6, 16'hBEEF, 1, 1'b0, 8'h00, acc1);
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", ready, 1);
        issue(4'hA, 16'h0000, 0, 1'b1, 8'h5E, acc2);
        wait_ready();

        // Random frames.
        for (int n = 0; n < 200; n++) begin
            issue(4'($urandom), 16'($urandom), int'($urandom_range(0, 2)), 1'b0, 8'h00, acc0);
            wait_ready();
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        check("monitor_idle", in_frame, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
